// File: rtl/ram_fill_check_pkg.sv
// Shared widths and state encoding for the RAM fill/check sequencer.
package ram_fill_check_pkg;

  localparam int unsigned DefAw    = 3;
  localparam int unsigned DefDw    = 8;
  localparam int unsigned DefDepth = 8;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

endpackage

// File: rtl/ram_fill_check.sv
// Fills the RAM with a seeded ramp, reads it back, and reports the sum and maximum of the words.
module ram_fill_check
  import ram_fill_check_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = DefDw
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    seed,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_wdata,
  output logic             ram_we,
  input  logic [DW-1:0]    ram_rdata,
  output logic             busy,
  output logic             done,
  output logic [DW+AW-1:0] sum,
  output logic [DW-1:0]    max
);

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DW-1:0]    seed_q, seed_d;
  logic             rvalid_q;
  logic [DW+AW-1:0] sum_q;
  logic [DW-1:0]    max_q;
  logic             accept;
  logic             last_idx;

  assign accept   = (state_q == StIdle) && start;
  assign last_idx = (idx_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seed_d  = seed_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          seed_d  = seed;
          idx_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (last_idx) begin
          idx_d   = '0;
          state_d = StRead;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StRead: begin
        if (last_idx) begin
          idx_d   = '0;
          state_d = StDrain;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      seed_q   <= '0;
      rvalid_q <= 1'b0;
      sum_q    <= '0;
      max_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      seed_q   <= seed_d;
      // Read data arrives one cycle after each READ address.
      rvalid_q <= (state_q == StRead);
      if (accept) begin
        sum_q <= '0;
        max_q <= '0;
      end else if (rvalid_q) begin
        sum_q <= sum_q + {{AW{1'b0}}, ram_rdata};
        if (ram_rdata > max_q) begin
          max_q <= ram_rdata;
        end
      end
    end
  end

  always_comb begin
    ram_we    = (state_q == StWrite);
    ram_addr  = ((state_q == StWrite) || (state_q == StRead)) ? idx_q : '0;
    ram_wdata = (state_q == StWrite) ? (seed_q + DW'(idx_q)) : '0;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    sum       = sum_q;
    max       = max_q;
  end

endmodule
